rpi_spi_master: RTL and testbench

SPI initiator for the 24-bit register frame used by the board's SPI register interface: 1 R/W bit, 7 address bits, 16 data bits, all MSB-first. It sits in the FPGA fabric and lets internal logic, or a self-test sequencer, drive register reads and writes on an SPI responder. A request/done handshake runs on the `clk` side; the block generates `spi_cs`, `spi_clk` and `spi_mosi`, and captures `spi_miso`.

---
 rtl/rpi_spi_master.sv | 200 ++++++++++++++++++++
 tb/tb_rpi_spi_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpi_spi_master.sv
// SPI initiator for the 24-bit {R/W, address, data} register frame, SPI mode 0, active-high chip select.
// Optional define SPI_MISO_SYNC_EN adds a 2-flop synchronizer on spi_miso (requires CLK_DIV >= 3).
module rpi_spi_master #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 16,
    parameter int CLK_DIV   = 4,
    parameter int CS_GAP    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 rw,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 spi_cs,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);
    localparam int FRAME   = 1 + ADDR_BITS + DATA_BITS;
    localparam int BCW     = $clog2(FRAME + 1);
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  GAP_LAST  = CW'(CS_GAP - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(FRAME);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME-2:0]     tx_sr_q, tx_sr_d;
    logic [DATA_BITS-1:0] rd_sr_q, rd_sr_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 rise;
    logic                 sample_en;
    logic                 sample_bit;
    logic [FRAME-1:0]     frame_load;
    logic                 half_end;
    logic                 gap_end;

    // Reads put zeros in the data field regardless of wr_data.
    assign frame_load = {rw, addr, (rw ? {DATA_BITS{1'b0}} : wr_data)};
    assign half_end   = (cnt_q == HALF_LAST);
    assign gap_end    = (cnt_q == GAP_LAST);

`ifdef SPI_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : g_bad_div
        $error("rpi_spi_master: CLK_DIV must be >= 3 when SPI_MISO_SYNC_EN is defined");
    end

    logic miso_s1_q, miso_s2_q, rise_d1_q, rise_d2_q;

    // Delaying the sample strobe by the synchronizer depth keeps the captured bit aligned to the rise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            rise_d1_q <= 1'b0;
            rise_d2_q <= 1'b0;
        end else begin
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
            rise_d1_q <= rise;
            rise_d2_q <= rise_d1_q;
        end
    end

    assign sample_en  = rise_d2_q;
    assign sample_bit = miso_s2_q;
`else
    if (CLK_DIV < 2) begin : g_bad_div
        $error("rpi_spi_master: CLK_DIV must be >= 2");
    end

    assign sample_en  = rise;
    assign sample_bit = spi_miso;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (half_end) state_d = SHIFT;
            // The trailing low half-period after the last bit belongs to SHIFT.
            SHIFT:   if (half_end && !sclk_q && bit_cnt_q == BIT_LAST) state_d = HOLD;
            HOLD:    if (half_end) state_d = GAP;
            GAP:     if (gap_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        rise      = 1'b0;
        if (state_d != state_q || state_q == IDLE || (state_q == SHIFT && half_end))
            cnt_d = '0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (start) begin
                    tx_sr_d = frame_load[FRAME-2:0];
                    mosi_d  = frame_load[FRAME-1];
                end
            end
            SETUP: begin
                if (half_end) begin
                    sclk_d    = 1'b1;
                    rise      = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == BIT_LAST) begin
                            mosi_d = 1'b0;
                        end else begin
                            mosi_d  = tx_sr_q[FRAME-2];
                            tx_sr_d = {tx_sr_q[FRAME-3:0], 1'b0};
                        end
                    end else if (bit_cnt_q != BIT_LAST) begin
                        sclk_d    = 1'b1;
                        rise      = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    done_d    = 1'b1;
                    rd_data_d = rd_sr_q;
                end
            end
            default: ;
        endcase
        cs_d   = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        rd_sr_d = rd_sr_q;
        if (sample_en) rd_sr_d = {rd_sr_q[DATA_BITS-2:0], sample_bit};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rd_sr_q   <= '0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rd_sr_q   <= rd_sr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign spi_cs   = cs_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_rpi_spi_master.sv
// Directed bench for rpi_spi_master: default-divider instance plus a minimum-divider instance.
module tb_rpi_spi_master;
    localparam int FRAME = 24;
    localparam int DIV   = 4;
    localparam int GAP   = 8;
`ifdef SPI_MISO_SYNC_EN
    localparam int SDIV  = 3;
`else
    localparam int SDIV  = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;

    logic        start_a = 0, rw_a = 0, miso_a = 0;
    logic [6:0]  addr_a = '0;
    logic [15:0] wd_a = '0;
    logic        busy_a, done_a, cs_a, sclk_a, mosi_a;
    logic [15:0] rd_a;

    logic        start_b = 0, rw_b = 0, miso_b = 0;
    logic [6:0]  addr_b = '0;
    logic [15:0] wd_b = '0;
    logic        busy_b, done_b, cs_b, sclk_b, mosi_b;
    logic [15:0] rd_b;

    rpi_spi_master #(.ADDR_BITS(7), .DATA_BITS(16), .CLK_DIV(DIV), .CS_GAP(GAP)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .rw(rw_a), .addr(addr_a),
        .wr_data(wd_a), .busy(busy_a), .done(done_a), .rd_data(rd_a),
        .spi_cs(cs_a), .spi_clk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a));

    rpi_spi_master #(.ADDR_BITS(7), .DATA_BITS(16), .CLK_DIV(SDIV), .CS_GAP(GAP)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .rw(rw_b), .addr(addr_b),
        .wr_data(wd_b), .busy(busy_b), .done(done_b), .rd_data(rd_b),
        .spi_cs(cs_b), .spi_clk(sclk_b), .spi_mosi(mosi_b), .spi_miso(miso_b));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor/responder for instance A: responder shifts out on spi_clk falls (mode 0).
    int cyc_a = 0, cs_rise_cyc_a = 0, cs_cnt_a = 0, cs_len_a = 0, rises_a = 0;
    int first_off_a = 0, last_off_a = 0, done_cnt_a = 0, done_cyc_a = 0;
    int busy_fall_cyc_a = 0, ridx_a = 0;
    logic cs_p_a = 0, sclk_p_a = 0, mosi_p_a = 0, busy_p_a = 0, chk_after_a = 0;
    logic [23:0] mosi_cap_a = '0, resp_a = '0;

    always @(negedge clk) begin
        cyc_a++;
        if (cs_a === 1'b1 && cs_p_a !== 1'b1) begin
            cs_rise_cyc_a = cyc_a; cs_cnt_a = 0; rises_a = 0; mosi_cap_a = '0;
            ridx_a = 0; miso_a = resp_a[23];
        end
        if (cs_a === 1'b1) cs_cnt_a++;
        if (cs_a !== 1'b1 && cs_p_a === 1'b1) cs_len_a = cs_cnt_a;
        if (sclk_a === 1'b1 && sclk_p_a === 1'b0) begin
            rises_a++;
            mosi_cap_a = {mosi_cap_a[22:0], mosi_a};
            if (rises_a == 1) first_off_a = cyc_a - cs_rise_cyc_a;
            last_off_a = cyc_a - cs_rise_cyc_a;
            chk("mosi_stable_before_rise_a", 32'(mosi_a), 32'(mosi_p_a));
            chk_after_a = 1;
        end else if (chk_after_a) begin
            if (reset_n === 1'b1) chk("mosi_stable_after_rise_a", 32'(mosi_a), 32'(mosi_p_a));
            chk_after_a = 0;
        end
        if (sclk_a === 1'b0 && sclk_p_a === 1'b1 && cs_a === 1'b1) begin
            ridx_a++;
            miso_a = (ridx_a < 24) ? resp_a[23-ridx_a] : 1'b0;
        end
        if (done_a === 1'b1) begin
            done_cnt_a++;
            done_cyc_a = cyc_a;
            chk("done_in_cs_fall_cycle_a", 32'({cs_p_a, cs_a}), 32'h2);
        end
        if (busy_a === 1'b0 && busy_p_a === 1'b1) busy_fall_cyc_a = cyc_a;
        cs_p_a = cs_a; sclk_p_a = sclk_a; mosi_p_a = mosi_a; busy_p_a = busy_a;
    end

    // Monitor/responder for instance B.
    int cs_cnt_b = 0, cs_len_b = 0, done_cnt_b = 0, ridx_b = 0;
    logic cs_p_b = 0, sclk_p_b = 0, mosi_p_b = 0, chk_after_b = 0;
    logic [23:0] resp_b = '0;

    always @(negedge clk) begin
        if (cs_b === 1'b1 && cs_p_b !== 1'b1) begin
            cs_cnt_b = 0; ridx_b = 0; miso_b = resp_b[23];
        end
        if (cs_b === 1'b1) cs_cnt_b++;
        if (cs_b !== 1'b1 && cs_p_b === 1'b1) cs_len_b = cs_cnt_b;
        if (sclk_b === 1'b1 && sclk_p_b === 1'b0) begin
            chk("mosi_stable_before_rise_b", 32'(mosi_b), 32'(mosi_p_b));
            chk_after_b = 1;
        end else if (chk_after_b) begin
            if (reset_n === 1'b1) chk("mosi_stable_after_rise_b", 32'(mosi_b), 32'(mosi_p_b));
            chk_after_b = 0;
        end
        if (sclk_b === 1'b0 && sclk_p_b === 1'b1 && cs_b === 1'b1) begin
            ridx_b++;
            miso_b = (ridx_b < 24) ? resp_b[23-ridx_b] : 1'b0;
        end
        if (done_b === 1'b1) done_cnt_b++;
        cs_p_b = cs_b; sclk_p_b = sclk_b; mosi_p_b = mosi_b;
    end

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [15:0] wd;
        logic [23:0] resp;
        logic [23:0] mosi;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs[6];

    task automatic wait_done_a(input int d0, input string name);
        bit got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge clk); #2;
            if (done_cnt_a != d0) got = 1;
        end
        chk(name, 32'(got), 32'd1);
    endtask

    task automatic do_frame(input vec_t v, input int poke);
        int d0;
        d0 = done_cnt_a;
        @(posedge clk); #1;
        resp_a = v.resp; rw_a = v.rw; addr_a = v.addr; wd_a = v.wd; start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        chk("busy_after_accept", 32'(busy_a), 32'd1);
        chk("cs_after_accept", 32'(cs_a), 32'd1);
        if (poke > 0) begin
            repeat (poke) @(posedge clk);
            #1;
            rw_a = ~v.rw; addr_a = ~v.addr; wd_a = ~v.wd; start_a = 1;
            @(posedge clk); #1;
            start_a = 0;
        end
        wait_done_a(d0, "done_seen");
        repeat (GAP + 6) @(posedge clk);
        #1;
        chk("done_count", 32'(done_cnt_a - d0), 32'd1);
        chk("mosi_frame", 32'(mosi_cap_a), 32'(v.mosi));
        chk("rise_count", 32'(rises_a), 32'(FRAME));
        chk("cs_high_cycles", 32'(cs_len_a), 32'(DIV * (2 * FRAME + 2)));
        chk("first_rise_offset", 32'(first_off_a), 32'(DIV));
        chk("last_rise_offset", 32'(last_off_a), 32'(DIV * (2 * FRAME - 1)));
        chk("done_offset", 32'(done_cyc_a - cs_rise_cyc_a), 32'(DIV * (2 * FRAME + 2)));
        chk("busy_fall_after_done", 32'(busy_fall_cyc_a - done_cyc_a), 32'(GAP));
        chk("idle_after_frame", 32'({busy_a, cs_a, sclk_a, mosi_a}), 32'd0);
        if (v.rw) chk("rd_data", 32'(rd_a), 32'(v.rd));
        $display("frame A rw=%0d addr=%02h wd=%04h poke=%0d mosi=%06h rd=%04h",
                 v.rw, v.addr, v.wd, poke, mosi_cap_a, rd_a);
    endtask

    task automatic run_b(input logic [23:0] resp, input logic [15:0] exp);
        int  d0;
        bit  got;
        d0 = done_cnt_b;
        got = 0;
        @(posedge clk); #1;
        resp_b = resp; rw_b = 1; addr_b = 7'h11; wd_b = 16'h0; start_b = 1;
        @(posedge clk); #1;
        start_b = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge clk); #2;
            if (done_cnt_b != d0) got = 1;
        end
        chk("done_seen_b", 32'(got), 32'd1);
        repeat (GAP + 6) @(posedge clk);
        #1;
        chk("done_count_b", 32'(done_cnt_b - d0), 32'd1);
        chk("cs_high_cycles_b", 32'(cs_len_b), 32'(SDIV * (2 * FRAME + 2)));
        chk("rd_data_b", 32'(rd_b), 32'(exp));
        $display("frame B div=%0d resp=%06h rd=%04h", SDIV, resp, rd_b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, dc;
        bit got;
        //                rw    addr    wd        resp          mosi          rd
        vecs[0] = '{1'b0, 7'h15, 16'hA5C3, 24'h000000, 24'h15A5C3, 16'h0000};
        vecs[1] = '{1'b1, 7'h02, 16'h5555, 24'h001234, 24'h820000, 16'h1234};
        vecs[2] = '{1'b1, 7'h7F, 16'hFFFF, 24'hFFABCD, 24'hFF0000, 16'hABCD};
        vecs[3] = '{1'b0, 7'h00, 16'hFFFF, 24'h123456, 24'h00FFFF, 16'h0000};
        vecs[4] = '{1'b1, 7'h40, 16'hBEEF, 24'h5A8001, 24'hC00000, 16'h8001};
        vecs[5] = '{1'b0, 7'h7F, 16'h0001, 24'h000000, 24'h7F0001, 16'h0000};

        reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_a", 32'({cs_a, sclk_a, mosi_a, busy_a, done_a}), 32'd0);
        chk("reset_rd_a", 32'(rd_a), 32'd0);
        chk("reset_outputs_b", 32'({cs_b, sclk_b, mosi_b, busy_b, done_b}), 32'd0);
        reset_n = 1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) do_frame(vecs[i], 0);

        // A second start partway through a frame must be dropped.
        do_frame(vecs[1], 50);

        // start held high: the next frame begins CS_GAP+1 cycles after done.
        d0 = done_cnt_a;
        @(posedge clk); #1;
        resp_a = 24'h00BEEF; rw_a = 1; addr_a = 7'h33; wd_a = 16'h0; start_a = 1;
        wait_done_a(d0, "b2b_first_done");
        chk("b2b_first_rd", 32'(rd_a), 32'h0000BEEF);
        resp_a = 24'h000F0F;
        dc = done_cyc_a;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #2;
            if (cs_rise_cyc_a > dc) got = 1;
        end
        chk("b2b_restart_seen", 32'(got), 32'd1);
        chk("b2b_restart_gap", 32'(cs_rise_cyc_a - dc), 32'(GAP + 1));
        start_a = 0;
        wait_done_a(d0 + 1, "b2b_second_done");
        chk("b2b_second_rd", 32'(rd_a), 32'h00000F0F);
        repeat (GAP + 6) @(posedge clk);
        #1;
        chk("b2b_done_count", 32'(done_cnt_a - d0), 32'd2);
        chk("b2b_idle", 32'({busy_a, cs_a}), 32'd0);
        $display("frame A back-to-back reads rd=%04h restart_gap=%0d", rd_a, cs_rise_cyc_a - dc);

        // Reset asserted right after the 10th spi_clk rise aborts the frame silently.
        d0 = done_cnt_a;
        @(posedge clk); #1;
        resp_a = 24'h00FFFF; rw_a = 0; addr_a = 7'h2A; wd_a = 16'h1357; start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (rises_a >= 10) break;
        end
        chk("abort_reached_rise10", 32'(rises_a >= 10), 32'd1);
        reset_n = 0;
        @(posedge clk); #1;
        chk("abort_outputs", 32'({cs_a, sclk_a, mosi_a, busy_a, done_a}), 32'd0);
        chk("abort_rd_cleared", 32'(rd_a), 32'd0);
        reset_n = 1;
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt_a - d0), 32'd0);
        chk("abort_stays_idle", 32'({busy_a, cs_a}), 32'd0);
        $display("frame A aborted by reset after rise %0d", rises_a);
        do_frame(vecs[0], 0);

        run_b(24'h00FFFF, 16'hFFFF);
        run_b(24'hFF0001, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
